// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: valid/ready input buffer, runtime baud divisor, per-frame
// length/parity/stop selection. Define UART_TX_FIFO_EN for a FIFO buffer with fifo_level.
module uart_tx_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [15:0]       baud_div,
  input  logic [3:0]        data_len,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              parity_out,
  output logic              tx_active,
  output logic              tx_done
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);

  if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_param_check
    $error("uart_tx_stream: illegal DATA_W or FIFO_DEPTH");
  end

  localparam logic [3:0] MaxLen = 4'(DATA_W);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic              push, pop, buf_empty;
  logic [DATA_W-1:0] buf_data;

  assign push = in_valid && in_ready;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   count_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + LvlW'(1);
      else if (pop && !push) count_q <= count_q - LvlW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready   = (count_q != LvlW'(FIFO_DEPTH));
  assign buf_empty  = (count_q == '0);
  assign buf_data   = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
`else
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_data_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= (hold_valid_q && !pop) || push;
      if (push) hold_data_q <= in_data;
    end
  end

  assign in_ready  = !hold_valid_q;
  assign buf_empty = !hold_valid_q;
  assign buf_data  = hold_data_q;
`endif

  state_e            state_q, state_d;
  logic [15:0]       timer_q, timer_d, div_q, div_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d, len_q, len_d, len_c;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d, done, load, par_calc, bit_end, last_bit;

  always_comb begin
    if (data_len < 4'd5)         len_c = 4'd5;
    else if (data_len > MaxLen)  len_c = MaxLen;
    else                         len_c = data_len;
  end

  // Parity covers only the bits that will actually be shifted out.
  always_comb begin
    par_calc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len_c)) par_calc = par_calc ^ buf_data[i];
    end
  end

  assign bit_end  = (timer_q == '0);
  assign last_bit = (bit_cnt_q == len_q - 4'd1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    done       = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;
    if (state_q != StIdle && !bit_end) timer_d = timer_q - 16'd1;
    case (state_q)
      StIdle: load = !buf_empty;
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          timer_d = div_q;
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d   = div_q;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          timer_d = div_q;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = div_q;
          end else begin
            done    = 1'b1;
            state_d = StIdle;
            load    = !buf_empty;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop from IDLE or from the end of STOP starts the next frame on this edge.
    if (load) begin
      pop        = 1'b1;
      state_d    = StStart;
      timer_d    = baud_div;
      div_d      = baud_div;
      len_d      = len_c;
      shift_d    = buf_data;
      bit_cnt_d  = 4'd0;
      stop2_d    = stop_bits;
      stop_cnt_d = 1'b0;
      par_en_d   = (parity_type == 2'b01) || (parity_type == 2'b10);
      par_d      = (parity_type == 2'b01) ? !par_calc :
                   (parity_type == 2'b10) ? par_calc : 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      len_q      <= 4'd5;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_done    <= done;
    end
  end

  // Line decoded from state so reset forces it high without waiting for a clock.
  always_comb begin
    data_out = 1'b1;
    case (state_q)
      StStart:  data_out = 1'b0;
      StData:   data_out = shift_q[0];
      StParity: data_out = par_q;
      default:  data_out = 1'b1;
    endcase
  end

  assign parity_out = par_q;
  assign tx_active  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed self-checking bench for uart_tx_stream; per-cycle waveforms are recorded after
// each accept edge and compared with hand-built frame bit strings.
module tb_uart_tx_stream;
  localparam int DataW     = 8;
  localparam int FifoDepth = 8;
`ifdef UART_TX_FIFO_EN
  localparam int Cap = FifoDepth;
`else
  localparam int Cap = 1;
`endif

  logic             clock = 1'b0;
  logic             rst;
  logic [15:0]      baud_div;
  logic [3:0]       data_len;
  logic [1:0]       parity_type;
  logic             stop_bits;
  logic [DataW-1:0] in_data;
  logic             in_valid;
  logic             in_ready, data_out, parity_out, tx_active, tx_done;
`ifdef UART_TX_FIFO_EN
  logic [$clog2(FifoDepth):0] fifo_level;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_stream #(.DATA_W(DataW), .FIFO_DEPTH(FifoDepth)) dut (
    .clock(clock), .rst(rst), .baud_div(baud_div), .data_len(data_len),
    .parity_type(parity_type), .stop_bits(stop_bits), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .parity_out(parity_out), .tx_active(tx_active), .tx_done(tx_done)
`ifdef UART_TX_FIFO_EN
    , .fifo_level(fifo_level)
`endif
  );

  always #5 clock = ~clock;

  // Expected line: bits[b] held for per cycles starting at cycle off, idle-high elsewhere.
  function automatic logic [255:0] wave(input logic [31:0] bits, input int nbits,
                                        input int per, input int off);
    logic [255:0] w;
    w = '1;
    for (int b = 0; b < nbits; b++)
      for (int p = 0; p < per; p++) w[off + b * per + p] = bits[b];
    return w;
  endfunction

  function automatic logic [255:0] span(input int off, input int len);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < len; i++) w[off + i] = 1'b1;
    return w;
  endfunction

  function automatic logic [255:0] pulse(input int pos);
    logic [255:0] w;
    w = '0;
    w[pos] = 1'b1;
    return w;
  endfunction

  // Cycle 0 is the cycle right after the accept edge.
  task automatic record(input int n, output logic [255:0] d, output logic [255:0] a,
                        output logic [255:0] t);
    d = '1;
    a = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      d[i] = data_out;
      a[i] = tx_active;
      t[i] = tx_done;
    end
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic push(input logic [7:0] w);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clock);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout word %h got in_ready=0 want 1", w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (data_out !== 1'b1)   begin errors++; $display("FAIL rst_data_out got %b want 1", data_out); end
    checks++; if (parity_out !== 1'b0) begin errors++; $display("FAIL rst_parity got %b want 0", parity_out); end
    checks++; if (tx_active !== 1'b0)  begin errors++; $display("FAIL rst_active got %b want 0", tx_active); end
    checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", tx_done); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
`ifdef UART_TX_FIFO_EN
    checks++; if (fifo_level !== '0)   begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
`endif
    @(posedge clock);
    #1 rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    logic [255:0] d, a, t, e;
    baud_div = 16'd3; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    push(8'hA5);
    fork
      record(44, d, a, t);
      begin
        // Inputs change after the frame is latched and must not disturb it.
        @(posedge clock);
        #1 baud_div = 16'd0; data_len = 4'd5; parity_type = 2'b10; stop_bits = 1'b1;
      end
    join
    @(posedge clock);
    #1;
    e = wave({1'b1, 8'hA5, 1'b0}, 10, 4, 1);
    checks++; if (d !== e) begin errors++; $display("FAIL basic_line got %h want %h", d, e); end
    checks++; if (a !== span(1, 40)) begin errors++; $display("FAIL basic_active got %h want %h", a, span(1, 40)); end
    checks++; if (t !== pulse(41)) begin errors++; $display("FAIL basic_done got %h want %h", t, pulse(41)); end
    checks++; if (parity_out !== 1'b0) begin errors++; $display("FAIL basic_parity got %b want 0", parity_out); end
  endtask

  task automatic test_parity();
    logic [255:0] d, a, t, e;
    baud_div = 16'd1; data_len = 4'd7; parity_type = 2'b10; stop_bits = 1'b0;
    push(8'h83);
    record(24, d, a, t);
    @(posedge clock);
    #1;
    e = wave({1'b1, 1'b0, 7'h03, 1'b0}, 10, 2, 1);
    checks++; if (d !== e) begin errors++; $display("FAIL even_line got %h want %h", d, e); end
    checks++; if (t !== pulse(21)) begin errors++; $display("FAIL even_done got %h want %h", t, pulse(21)); end
    checks++; if (parity_out !== 1'b0) begin errors++; $display("FAIL even_parity got %b want 0", parity_out); end
    parity_type = 2'b01;
    push(8'h03);
    record(24, d, a, t);
    @(posedge clock);
    #1;
    e = wave({1'b1, 1'b1, 7'h03, 1'b0}, 10, 2, 1);
    checks++; if (d !== e) begin errors++; $display("FAIL odd_line got %h want %h", d, e); end
    checks++; if (a !== span(1, 20)) begin errors++; $display("FAIL odd_active got %h want %h", a, span(1, 20)); end
    checks++; if (parity_out !== 1'b1) begin errors++; $display("FAIL odd_parity got %b want 1", parity_out); end
  endtask

  task automatic test_len_clamp();
    logic [255:0] d, a, t, e;
    baud_div = 16'd0; data_len = 4'd2; parity_type = 2'b10; stop_bits = 1'b0;
    push(8'hFF);
    record(14, d, a, t);
    @(posedge clock);
    #1;
    e = wave({1'b1, 1'b1, 5'h1F, 1'b0}, 8, 1, 1);
    checks++; if (d !== e) begin errors++; $display("FAIL len2_line got %h want %h", d, e); end
    checks++; if (a !== span(1, 8)) begin errors++; $display("FAIL len2_active got %h want %h", a, span(1, 8)); end
    data_len = 4'd15; parity_type = 2'b11;
    push(8'h5A);
    record(14, d, a, t);
    @(posedge clock);
    #1;
    e = wave({1'b1, 8'h5A, 1'b0}, 10, 1, 1);
    checks++; if (d !== e) begin errors++; $display("FAIL len15_line got %h want %h", d, e); end
    checks++; if (t !== pulse(11)) begin errors++; $display("FAIL len15_done got %h want %h", t, pulse(11)); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d, a, t, e;
    baud_div = 16'd0; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b1;
    push(8'h0F);
    fork
      record(26, d, a, t);
      push(8'hF0);
    join
    @(posedge clock);
    #1;
    e = wave({2'b11, 8'h0F, 1'b0}, 11, 1, 1) & wave({2'b11, 8'hF0, 1'b0}, 11, 1, 12);
    checks++; if (d !== e) begin errors++; $display("FAIL b2b_line got %h want %h", d, e); end
    checks++; if (a !== span(1, 22)) begin errors++; $display("FAIL b2b_active got %h want %h", a, span(1, 22)); end
    e = pulse(12) | pulse(23);
    checks++; if (t !== e) begin errors++; $display("FAIL b2b_done got %h want %h", t, e); end
  endtask

  task automatic test_fill();
    logic [255:0] d, a, t, ed, et;
    logic [7:0] words [9];
    logic [7:0] w;
    int bad;
    words = '{8'h01, 8'h1E, 8'h13, 8'h0C, 8'h15, 8'h0A, 8'h17, 8'h08, 8'h1B};
    baud_div = 16'd1; data_len = 4'd5; parity_type = 2'b00; stop_bits = 1'b0;
    bad = 0;
    push(words[0]);
    fork
      record(14 * (Cap + 1) + 4, d, a, t);
      begin
        for (int j = 1; j <= Cap; j++) push(words[j]);
        // Buffer is full: this word must be refused.
        in_data  = 8'h00;
        in_valid = 1'b1;
        repeat (4) begin
          @(negedge clock);
          if (in_ready !== 1'b0) bad++;
          @(posedge clock);
          #1;
        end
        in_valid = 1'b0;
      end
`ifdef UART_TX_FIFO_EN
      begin
        repeat (15) @(negedge clock);
        checks++; if (int'(fifo_level) !== FifoDepth) begin errors++; $display("FAIL fill_level0 got %0d want %0d", fifo_level, FifoDepth); end
        @(negedge clock);
        checks++; if (int'(fifo_level) !== FifoDepth - 1) begin errors++; $display("FAIL fill_level1 got %0d want %0d", fifo_level, FifoDepth - 1); end
        repeat (14) @(negedge clock);
        checks++; if (int'(fifo_level) !== FifoDepth - 2) begin errors++; $display("FAIL fill_level2 got %0d want %0d", fifo_level, FifoDepth - 2); end
      end
`endif
    join
    @(posedge clock);
    #1;
    ed = '1;
    et = '0;
    for (int j = 0; j <= Cap; j++) begin
      w  = words[j];
      ed = ed & wave({1'b1, w[4:0], 1'b0}, 7, 2, 1 + 14 * j);
      et = et | pulse(15 + 14 * j);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_ready got %0d high cycles want 0", bad); end
    checks++; if (d !== ed) begin errors++; $display("FAIL fill_line got %h want %h", d, ed); end
    checks++; if (a !== span(1, 14 * (Cap + 1))) begin errors++; $display("FAIL fill_active got %h want %h", a, span(1, 14 * (Cap + 1))); end
    checks++; if (t !== et) begin errors++; $display("FAIL fill_done got %h want %h", t, et); end
  endtask

  task automatic test_reset_mid();
    int bad;
    baud_div = 16'd3; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    push(8'h00);
    push(8'h55);
    repeat (6) @(posedge clock);
    @(negedge clock);
    checks++; if ({data_out, tx_active} !== 2'b01) begin errors++; $display("FAIL mid_pre got %b want 01", {data_out, tx_active}); end
    #2 rst = 1'b1;
    #1;
    checks++; if (data_out !== 1'b1)  begin errors++; $display("FAIL mid_line got %b want 1", data_out); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL mid_active got %b want 0", tx_active); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
`ifdef UART_TX_FIFO_EN
    checks++; if (fifo_level !== '0)  begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
`endif
    @(posedge clock);
    #1 rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_quiet got %0d busy cycles want 0", bad); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; baud_div = '0; data_len = 4'd8;
    parity_type = 2'b00; stop_bits = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_len_clamp();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish before 500000");
    $fatal(1);
  end

endmodule
